// File: rtl/al_param_fetch.sv
// Autoload parameter fetch: reads header/threshold/check words from flash and hands the threshold to the DAC loader.
// Optional build macro AL_CHKSUM_EN enables verification of the check word (header XOR threshold word).
//
// state | meaning
// IDLE  | waiting for AL_START after reset
// CLR   | clear downstream done flag
// HDR   | read and validate header word
// THR   | read threshold word
// CHK   | read check word
// CAPT  | strobe new threshold into the DAC loader
// WDONE | wait for the DAC loader to finish
// DFLT  | strobe default threshold load
// WDFLT | wait for default load to finish
// DONE  | flash value applied
// FAIL  | failure, default applied or attempted
module al_param_fetch #(
  parameter int          TIMEOUT = 40000,
  parameter logic [15:0] MAGIC   = 16'hA1C5
) (
  input  logic        CLK40,
  input  logic        RST,
  input  logic        AL_START,
  output logic        RD_REQ,
  input  logic        RD_VALID,
  input  logic [15:0] RD_DATA,
  output logic        CLR_AL_DONE,
  output logic        CAPTURE,
  output logic        LOAD_DFLT,
  output logic [11:0] BPI_AL_REG,
  input  logic        CDAC_DONE,
  output logic        AL_DONE,
  output logic        AL_ERR,
  output logic [2:0]  ERR_CODE
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, CLR, HDR, THR, CHK, CAPT, WDONE, DFLT, WDFLT, DONE, FAIL
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmr;
  logic [11:0]   thr;
  logic [2:0]    err_nxt;
  logic          tmo, rd_ok, chk_ok, thr_ld;

  assign tmo = (tmr == TMR_LAST);
  // The request cycle itself is not a wait cycle; data is taken from the following cycle on.
  assign rd_ok = RD_VALID && !RD_REQ;

`ifdef AL_CHKSUM_EN
  logic [3:0] thr_hi;

  always_ff @(posedge CLK40) begin
    if (thr_ld) thr_hi <= RD_DATA[15:12];
  end

  assign chk_ok = (RD_DATA == (MAGIC ^ {thr_hi, thr}));
`else
  assign chk_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    err_nxt   = ERR_CODE;
    thr_ld    = 1'b0;
    case (state)
      IDLE, DONE, FAIL: begin
        if (AL_START) begin
          state_nxt = CLR;
          err_nxt   = 3'b000;
        end
      end
      CLR: state_nxt = HDR;
      HDR: begin
        if (rd_ok) begin
          if (RD_DATA == MAGIC) begin
            state_nxt = THR;
          end else begin
            state_nxt = DFLT;
            err_nxt   = 3'b010;
          end
        end else if (tmo) begin
          state_nxt = DFLT;
          err_nxt   = 3'b001;
        end
      end
      THR: begin
        if (rd_ok) begin
          thr_ld    = 1'b1;
          state_nxt = CHK;
        end else if (tmo) begin
          state_nxt = DFLT;
          err_nxt   = 3'b001;
        end
      end
      CHK: begin
        if (rd_ok) begin
          if (chk_ok) begin
            state_nxt = CAPT;
          end else begin
            state_nxt = DFLT;
            err_nxt   = 3'b011;
          end
        end else if (tmo) begin
          state_nxt = DFLT;
          err_nxt   = 3'b001;
        end
      end
      CAPT: state_nxt = WDONE;
      WDONE: begin
        if (CDAC_DONE) begin
          state_nxt = DONE;
        end else if (tmo) begin
          state_nxt = DFLT;
          err_nxt   = 3'b100;
        end
      end
      DFLT: state_nxt = WDFLT;
      WDFLT: begin
        if (CDAC_DONE || tmo) begin
          state_nxt = FAIL;
          if (!CDAC_DONE && ERR_CODE == 3'b000) err_nxt = 3'b100;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK40) begin
    if (RST) begin
      state       <= IDLE;
      tmr         <= '0;
      thr         <= '0;
      RD_REQ      <= 1'b0;
      CLR_AL_DONE <= 1'b0;
      CAPTURE     <= 1'b0;
      LOAD_DFLT   <= 1'b0;
      AL_DONE     <= 1'b0;
      AL_ERR      <= 1'b0;
      ERR_CODE    <= 3'b000;
      BPI_AL_REG  <= 12'hFDD;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || !(state_nxt inside {HDR, THR, CHK, WDONE, WDFLT}))
        tmr <= '0;
      else
        tmr <= tmr + TW'(1);
      RD_REQ      <= (state_nxt != state) && (state_nxt inside {HDR, THR, CHK});
      CLR_AL_DONE <= (state_nxt == CLR);
      CAPTURE     <= (state_nxt == CAPT);
      LOAD_DFLT   <= (state_nxt == DFLT);
      AL_DONE     <= (state_nxt == DONE);
      AL_ERR      <= (state_nxt == FAIL);
      ERR_CODE    <= err_nxt;
      if (thr_ld) thr <= RD_DATA[11:0];
      // Threshold becomes visible on the same edge that raises CAPTURE.
      if (state == CHK && state_nxt == CAPT) BPI_AL_REG <= thr;
    end
  end

endmodule

// File: tb/tb_al_param_fetch.sv
// Scoreboard bench for al_param_fetch: stimulus queues expected strobes, a negedge monitor checks them.
module tb_al_param_fetch;
  localparam int TMO = 16;

  logic        CLK40 = 1'b0;
  logic        RST, AL_START, RD_VALID, CDAC_DONE;
  logic [15:0] RD_DATA;
  logic        RD_REQ, CLR_AL_DONE, CAPTURE, LOAD_DFLT, AL_DONE, AL_ERR;
  logic [11:0] BPI_AL_REG;
  logic [2:0]  ERR_CODE;

  al_param_fetch #(.TIMEOUT(TMO), .MAGIC(16'hA1C5)) dut (
    .CLK40(CLK40), .RST(RST), .AL_START(AL_START), .RD_REQ(RD_REQ),
    .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .CLR_AL_DONE(CLR_AL_DONE),
    .CAPTURE(CAPTURE), .LOAD_DFLT(LOAD_DFLT), .BPI_AL_REG(BPI_AL_REG),
    .CDAC_DONE(CDAC_DONE), .AL_DONE(AL_DONE), .AL_ERR(AL_ERR), .ERR_CODE(ERR_CODE)
  );

  always #5 CLK40 = ~CLK40;

  // kind: 0 CLR_AL_DONE, 1 RD_REQ, 2 CAPTURE, 3 LOAD_DFLT; gap = cycles since previous strobe (-1 = any)
  typedef struct { int kind; int gap; logic [11:0] bpi; } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  int cyc = 0, last_cyc = 0;
  int m_n, m_kind;
  logic m_bad;

  always @(posedge CLK40) cyc <= cyc + 1;

  always @(negedge CLK40) begin
    m_n = int'(RD_REQ) + int'(CLR_AL_DONE) + int'(CAPTURE) + int'(LOAD_DFLT);
    if (m_n > 0) begin
      m_kind = CLR_AL_DONE ? 0 : RD_REQ ? 1 : CAPTURE ? 2 : 3;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, expected no strobe", m_kind, cyc);
      end else begin
        e = q.pop_front();
        m_bad = (m_n != 1) || (m_kind != e.kind) ||
                (e.gap >= 0 && (cyc - last_cyc) != e.gap) ||
                (m_kind == 2 && BPI_AL_REG != e.bpi);
        if (m_bad) begin
          errors++;
          $display("FAIL strobe: got kind %0d count %0d gap %0d bpi %h, expected kind %0d gap %0d bpi %h",
                   m_kind, m_n, cyc - last_cyc, BPI_AL_REG, e.kind, e.gap, e.bpi);
        end
      end
      last_cyc = cyc;
    end
  end

  task automatic push(input int kind, input int gap, input logic [11:0] bpi);
    exp_t x;
    x.kind = kind; x.gap = gap; x.bpi = bpi;
    q.push_back(x);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK40);
  endtask

  task automatic start();
    AL_START = 1'b1; tick(1); AL_START = 1'b0;
  endtask

  task automatic respond(input logic [15:0] w, input int dly);
    int k = 0;
    while (!RD_REQ && k < 100) begin tick(1); k++; end
    if (k >= 100) chk("rd_req_wait", 0, 1);
    tick(dly);
    RD_VALID = 1'b1; RD_DATA = w;
    tick(1);
    RD_VALID = 1'b0;
  endtask

  task automatic wait_load();
    int k = 0;
    while (!LOAD_DFLT && k < 200) begin tick(1); k++; end
    chk("load_dflt_seen", int'(LOAD_DFLT), 1);
  endtask

  task automatic cdac_pulse();
    CDAC_DONE = 1'b1; tick(1); CDAC_DONE = 1'b0; tick(2);
  endtask

  task automatic status(input string nm, input int done, input int err, input int code, input int bpi);
    chk({nm, "_al_done"}, int'(AL_DONE), done);
    chk({nm, "_al_err"}, int'(AL_ERR), err);
    chk({nm, "_err_code"}, int'(ERR_CODE), code);
    chk({nm, "_bpi"}, int'(BPI_AL_REG), bpi);
  endtask

  task automatic reset_vals(input string nm);
    chk({nm, "_rd_req"}, int'(RD_REQ), 0);
    chk({nm, "_clr"}, int'(CLR_AL_DONE), 0);
    chk({nm, "_capture"}, int'(CAPTURE), 0);
    chk({nm, "_load_dflt"}, int'(LOAD_DFLT), 0);
    status(nm, 0, 0, 0, 12'hFDD);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cs_code, cs_done, cs_err;
    RST = 1'b1; AL_START = 1'b0; RD_VALID = 1'b0; RD_DATA = '0; CDAC_DONE = 1'b0;
    tick(3);
    reset_vals("reset");

    // Bad header straight out of reset; start accepted on first cycle after reset.
    push(0, -1, 0); push(1, 1, 0); push(3, 2, 0);
    RST = 1'b0;
    start();
    respond(16'h1234, 1);
    tick(4);
    cdac_pulse();
    status("bad_hdr", 0, 1, 2, 12'hFDD);

    // Normal load.
    push(0, -1, 0); push(1, 1, 0); push(1, 2, 0); push(1, 2, 0); push(2, 2, 12'hABC);
    start();
    respond(16'hA1C5, 1); respond(16'h0ABC, 1); respond(16'hAB79, 1);
    tick(8);
    chk("wdone_not_done_yet", int'(AL_DONE), 0);
    cdac_pulse();
    status("normal", 1, 0, 0, 12'hABC);

    // Zero check word.
    push(0, -1, 0); push(1, 1, 0); push(1, 2, 0); push(1, 2, 0);
`ifdef AL_CHKSUM_EN
    push(3, 2, 0); cs_done = 0; cs_err = 1; cs_code = 3;
`else
    push(2, 2, 12'hABC); cs_done = 1; cs_err = 0; cs_code = 0;
`endif
    start();
    respond(16'hA1C5, 1); respond(16'h0ABC, 1); respond(16'h0000, 1);
    tick(8);
    cdac_pulse();
    status("chk_zero", cs_done, cs_err, cs_code, 12'hABC);

    // Threshold word never arrives.
    push(0, -1, 0); push(1, 1, 0); push(1, 2, 0); push(3, TMO, 0);
    start();
    respond(16'hA1C5, 1);
    wait_load();
    tick(2);
    cdac_pulse();
    status("rd_timeout", 0, 1, 1, 12'hABC);

    // Threshold word arrives on the last cycle before expiry.
    push(0, -1, 0); push(1, 1, 0); push(1, 2, 0); push(1, TMO, 0); push(2, 2, 12'h055);
    start();
    respond(16'hA1C5, 1); respond(16'h0055, TMO - 1); respond(16'hA190, 1);
    tick(8);
    cdac_pulse();
    status("late_valid", 1, 0, 0, 12'h055);

    // DAC loader never completes.
    push(0, -1, 0); push(1, 1, 0); push(1, 2, 0); push(1, 2, 0); push(2, 2, 12'h3C3);
    push(3, TMO + 1, 0);
    start();
    respond(16'hA1C5, 1); respond(16'h03C3, 1); respond(16'hA206, 1);
    wait_load();
    chk("cdac_tmo_err_at_dflt", int'(ERR_CODE), 4);
    k = 0;
    while (!AL_ERR && k < 100) begin tick(1); k++; end
    chk("wdflt_timeout_cycles", k, TMO + 1);
    status("cdac_tmo", 0, 1, 4, 12'h3C3);

    // Restart ignored mid-read, then reset during WDONE.
    push(0, -1, 0); push(1, 1, 0); push(1, 2, 0); push(1, 2, 0); push(2, 2, 12'h123);
    start();
    respond(16'hA1C5, 1);
    AL_START = 1'b1; tick(1); AL_START = 1'b0;
    RD_VALID = 1'b1; RD_DATA = 16'h0123; tick(1); RD_VALID = 1'b0;
    respond(16'hA0E6, 1);
    tick(3);
    RST = 1'b1; tick(1); RST = 1'b0;
    reset_vals("mid_reset");
    tick(6);

    chk("expected_strobes_left", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
